// File: rtl/barrier_pkg.sv
// Shared widths and types for the barrier arrival path.
// Holds the core-id width helper and default mask/id types.
package barrier_pkg;

    localparam int NUM_CORES_DEF = 4;

    function automatic int core_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CORE_ID_W = core_id_w(NUM_CORES_DEF);

    typedef logic [NUM_CORES_DEF-1:0] core_mask_t;
    typedef logic [CORE_ID_W-1:0]     core_id_t;

endpackage

// File: rtl/barrier_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant of the first request found
// when searching upward from ptr, wrapping at NUM_CORES.
module barrier_rr_arbiter
    import barrier_pkg::*;
#(
    parameter  int NUM_CORES = NUM_CORES_DEF,
    localparam int IDW       = core_id_w(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDW-1:0]       ptr,
    output logic [NUM_CORES-1:0] gnt,
    output logic [IDW-1:0]       gnt_idx,
    output logic                 gnt_valid
);

    always_comb begin
        int k;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        k         = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            k = (int'(ptr) + i) % NUM_CORES;
            if (!gnt_valid && req[k]) begin
                gnt[k]    = 1'b1;
                gnt_idx   = IDW'(k);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/barrier_arrival_collector.sv
// Buffers per-core barrier arrivals, feeds the counter one per cycle and turns
// counter events into registered release pulses. Optional: BARRIER_DUP_CHECK_EN.
module barrier_arrival_collector
    import barrier_pkg::*;
#(
    parameter  int NUM_CORES = NUM_CORES_DEF,
    localparam int IDW       = core_id_w(NUM_CORES)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_CORES-1:0] core_arrive_i,
    input  logic [NUM_CORES-1:0] barrier_event_i,
    input  logic                 clear_req_i,
    output logic                 barrier_get_o,
    output logic [NUM_CORES-1:0] arrival_gnt_o,
    output logic [NUM_CORES-1:0] core_waiting_o,
    output logic [NUM_CORES-1:0] core_release_o,
    output logic                 err_o,
    output logic [IDW-1:0]       err_core_o
);

    logic [NUM_CORES-1:0] pending_q, waiting_q, release_q;
    logic [IDW-1:0]       rr_ptr_q;

    logic                 stall;
    logic [NUM_CORES-1:0] arb_req, gnt;
    logic [IDW-1:0]       gnt_idx, ptr_next;
    logic                 gnt_valid;
    logic [NUM_CORES-1:0] dup_mask, accept;

    // Handshake: the counter has no ready; barrier_get_o/arrival_gnt_o are
    // counted in the same cycle they are high, so a grant is only issued when
    // nothing (event or clear) would wipe the counter at the coming edge.
    assign stall   = clear_req_i | (|barrier_event_i);
    assign arb_req = stall ? '0 : pending_q;

    barrier_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .req       (arb_req),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign arrival_gnt_o  = gnt;
    assign barrier_get_o  = gnt_valid;
    assign core_waiting_o = waiting_q;
    assign core_release_o = release_q;

    assign ptr_next = (gnt_idx == IDW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef BARRIER_DUP_CHECK_EN
    logic           err_q;
    logic [IDW-1:0] err_core_q, dup_idx;

    assign dup_mask = core_arrive_i & (pending_q | waiting_q);

    // Lowest offending index wins when several cores misbehave together.
    always_comb begin
        dup_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (dup_mask[i]) dup_idx = IDW'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q      <= 1'b0;
            err_core_q <= '0;
        end else if (clear_req_i) begin
            err_q      <= 1'b0;
            err_core_q <= '0;
        end else begin
            err_q <= |dup_mask;
            if (|dup_mask) err_core_q <= dup_idx;
        end
    end

    assign err_o      = err_q;
    assign err_core_o = err_core_q;
`else
    assign dup_mask   = '0;
    assign err_o      = 1'b0;
    assign err_core_o = '0;
`endif

    assign accept = core_arrive_i & ~dup_mask;

    // A same-cycle arrival re-arms pending even while that core is being granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            waiting_q <= '0;
            release_q <= '0;
            rr_ptr_q  <= '0;
        end else if (clear_req_i) begin
            pending_q <= '0;
            waiting_q <= '0;
            release_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            pending_q <= (pending_q & ~gnt) | accept;
            waiting_q <= (waiting_q & ~barrier_event_i) | gnt;
            release_q <= barrier_event_i & waiting_q;
            if (gnt_valid) rr_ptr_q <= ptr_next;
        end
    end

endmodule

// File: tb/tb_barrier_arrival_collector.sv
// Randomized and directed bench for barrier_arrival_collector (NUM_CORES=4)
// against a cycle-level reference model; follows BARRIER_DUP_CHECK_EN if defined.
module tb_barrier_arrival_collector;

    localparam int N = 4;

    logic         clk;
    logic         rst_ni;
    logic [N-1:0] core_arrive;
    logic [N-1:0] barrier_event;
    logic         clear_req;
    logic         barrier_get;
    logic [N-1:0] arrival_gnt;
    logic [N-1:0] core_waiting;
    logic [N-1:0] core_release;
    logic         err;
    logic [1:0]   err_core;

    int n_cmp = 0;
    int n_err = 0;

    logic [N-1:0] exp_q[$];

    // reference model state
    logic [N-1:0] m_pend, m_wait, m_rel;
    int           m_ptr;
    logic         m_err;
    logic [1:0]   m_errc;

    barrier_arrival_collector #(.NUM_CORES(N)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .core_arrive_i   (core_arrive),
        .barrier_event_i (barrier_event),
        .clear_req_i     (clear_req),
        .barrier_get_o   (barrier_get),
        .arrival_gnt_o   (arrival_gnt),
        .core_waiting_o  (core_waiting),
        .core_release_o  (core_release),
        .err_o           (err),
        .err_core_o      (err_core)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_wait = '0;
        m_rel  = '0;
        m_ptr  = 0;
        m_err  = 1'b0;
        m_errc = '0;
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_get"},  {31'd0, barrier_get}, 32'd0);
        check({tag, "_gnt"},  {28'd0, arrival_gnt}, 32'd0);
        check({tag, "_wait"}, {28'd0, core_waiting}, 32'd0);
        check({tag, "_rel"},  {28'd0, core_release}, 32'd0);
        check({tag, "_err"},  {31'd0, err}, 32'd0);
        check({tag, "_errc"}, {30'd0, err_core}, 32'd0);
    endtask

    // Compare the DUT for the current cycle, then advance the model one edge.
    task automatic model_step(input logic [N-1:0] arr, input logic [N-1:0] ev, input logic clr);
        int           gidx;
        int           k;
        logic [N-1:0] gmask, off, npend, nwait, nrel;
        gidx  = -1;
        gmask = '0;
        off   = '0;
        if (!clr && ev == '0) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (gidx < 0 && m_pend[k]) gidx = k;
            end
        end
        if (gidx >= 0) gmask[gidx] = 1'b1;
        exp_q.push_back(gmask);

        check("get",     {31'd0, barrier_get}, (gidx >= 0) ? 32'd1 : 32'd0);
        check("gnt",     {28'd0, arrival_gnt}, {28'd0, exp_q.pop_front()});
        check("waiting", {28'd0, core_waiting}, {28'd0, m_wait});
        check("release", {28'd0, core_release}, {28'd0, m_rel});
        check("err",     {31'd0, err}, {31'd0, m_err});
        check("err_core",{30'd0, err_core}, {30'd0, m_errc});

`ifdef BARRIER_DUP_CHECK_EN
        for (int i = 0; i < N; i++) off[i] = arr[i] && (m_pend[i] || m_wait[i]);
`endif
        if (clr) begin
            m_pend = '0;
            m_wait = '0;
            m_rel  = '0;
            m_ptr  = 0;
            m_err  = 1'b0;
            m_errc = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                nrel[i]  = ev[i] && m_wait[i];
                nwait[i] = (m_wait[i] && !ev[i]) || gmask[i];
                npend[i] = (m_pend[i] && !gmask[i]) || (arr[i] && !off[i]);
            end
            m_pend = npend;
            m_wait = nwait;
            m_rel  = nrel;
            if (gidx >= 0) m_ptr = (gidx + 1) % N;
`ifdef BARRIER_DUP_CHECK_EN
            m_err = (off != '0);
            for (int i = N - 1; i >= 0; i--) begin
                if (off[i]) m_errc = 2'(i);
            end
`endif
        end
    endtask

    // driver: apply one cycle of inputs just after the edge, check before the next
    task automatic drive_cycle(input logic [N-1:0] arr, input logic [N-1:0] ev, input logic clr);
        @(posedge clk);
        #1;
        core_arrive   = arr;
        barrier_event = ev;
        clear_req     = clr;
        #1;
        model_step(arr, ev, clr);
    endtask

    task automatic random_cycles(input int n);
        logic [N-1:0] arr, ev;
        logic         clr;
        for (int c = 0; c < n; c++) begin
            arr = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
            ev  = ($urandom_range(0, 6) == 0) ? N'($urandom_range(1, 15)) : '0;
            clr = ($urandom_range(0, 39) == 0);
            drive_cycle(arr, ev, clr);
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        core_arrive   = '0;
        barrier_event = '0;
        clear_req     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_ni = 1'b1;

        // single arrival: get next cycle, waiting the cycle after
        drive_cycle(4'b0001, 4'b0000, 1'b0);
        drive_cycle(4'b0000, 4'b0000, 1'b0);
        drive_cycle(4'b0000, 4'b0000, 1'b0);
        // clear to restart the pointer, then all four arrive together
        drive_cycle(4'b0000, 4'b0000, 1'b1);
        drive_cycle(4'b1111, 4'b0000, 1'b0);
        repeat (5) drive_cycle(4'b0000, 4'b0000, 1'b0);
        // core 2 re-arrives; the event cycle stalls its grant
        drive_cycle(4'b0100, 4'b0000, 1'b0);
        drive_cycle(4'b0000, 4'b1111, 1'b0);
        repeat (3) drive_cycle(4'b0000, 4'b0000, 1'b0);
        drive_cycle(4'b0000, 4'b0100, 1'b0);
        drive_cycle(4'b0000, 4'b0000, 1'b0);
        // clear with concurrent arrivals and a pending core
        drive_cycle(4'b1000, 4'b0000, 1'b0);
        drive_cycle(4'b0011, 4'b0000, 1'b1);
        repeat (2) drive_cycle(4'b0000, 4'b0000, 1'b0);
        // arrival from a core already waiting, then a pending duplicate
        drive_cycle(4'b0010, 4'b0000, 1'b0);
        repeat (2) drive_cycle(4'b0000, 4'b0000, 1'b0);
        drive_cycle(4'b0010, 4'b0000, 1'b0);
        repeat (2) drive_cycle(4'b0000, 4'b0000, 1'b0);
        drive_cycle(4'b0101, 4'b0000, 1'b0);
        drive_cycle(4'b0101, 4'b0000, 1'b0);
        repeat (3) drive_cycle(4'b0000, 4'b0000, 1'b0);
        drive_cycle(4'b0000, 4'b0000, 1'b1);
        drive_cycle(4'b0000, 4'b0000, 1'b0);

        random_cycles(600);

        // asynchronous reset in the middle of activity
        drive_cycle(4'b1111, 4'b0000, 1'b0);
        drive_cycle(4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #3;
        core_arrive   = '0;
        barrier_event = '0;
        clear_req     = 1'b0;
        rst_ni        = 1'b0;
        #1;
        check_idle_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;

        random_cycles(200);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
